// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the load-hazard scoreboard unit.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned NUM_SRC_DEF = 2;
  localparam int unsigned MAX_OUT_DEF = 2;
  localparam int unsigned REG_ZERO    = 0;

  // Width of the outstanding-load counter: must hold 0..max_out inclusive.
  function automatic int unsigned CNT_W(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard bus: operand/issue/response inputs and pipeline control outputs.
// Optional macro HAZARD_PERF_CNT_EN adds the StallCnt_o performance counter.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
);

  logic [NUM_SRC*REG_AW-1:0] IFID_RS_i;
  logic [NUM_SRC-1:0]        IFID_RSUse_i;
  logic                      IFID_MemRead_i;
  logic                      IDEX_MemRead_i;
  logic [REG_AW-1:0]         IDEX_RD_i;
  logic                      Issue_i;
  logic [REG_AW-1:0]         Issue_RD_i;
  logic                      MemResp_i;
  logic [REG_AW-1:0]         MemResp_RD_i;
  logic                      Flush_i;
  logic                      PCWrite_o;
  logic                      Stall_o;
  logic                      NoOp_o;
  logic                      Full_o;
  logic                      Err_o;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]               StallCnt_o;

  modport master (
    output IFID_RS_i, IFID_RSUse_i, IFID_MemRead_i, IDEX_MemRead_i, IDEX_RD_i,
    output Issue_i, Issue_RD_i, MemResp_i, MemResp_RD_i, Flush_i,
    input  PCWrite_o, Stall_o, NoOp_o, Full_o, Err_o, StallCnt_o
  );

  modport slave (
    input  IFID_RS_i, IFID_RSUse_i, IFID_MemRead_i, IDEX_MemRead_i, IDEX_RD_i,
    input  Issue_i, Issue_RD_i, MemResp_i, MemResp_RD_i, Flush_i,
    output PCWrite_o, Stall_o, NoOp_o, Full_o, Err_o, StallCnt_o
  );
`else
  modport master (
    output IFID_RS_i, IFID_RSUse_i, IFID_MemRead_i, IDEX_MemRead_i, IDEX_RD_i,
    output Issue_i, Issue_RD_i, MemResp_i, MemResp_RD_i, Flush_i,
    input  PCWrite_o, Stall_o, NoOp_o, Full_o, Err_o
  );

  modport slave (
    input  IFID_RS_i, IFID_RSUse_i, IFID_MemRead_i, IDEX_MemRead_i, IDEX_RD_i,
    input  Issue_i, Issue_RD_i, MemResp_i, MemResp_RD_i, Flush_i,
    output PCWrite_o, Stall_o, NoOp_o, Full_o, Err_o
  );
`endif

endinterface

// File: rtl/hazard_sb_core.sv
// Scoreboard state: per-register pending bits, outstanding-load counter and
// sticky protocol error, with their next-edge update rules.
module hazard_sb_core
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_issue,
  input  logic [REG_AW-1:0]             i_issue_rd,
  input  logic                          i_resp,
  input  logic [REG_AW-1:0]             i_resp_rd,
  output logic [(2**REG_AW)-1:0]        o_pend,
  output logic [CNT_W(MAX_OUT)-1:0]     o_out_cnt,
  output logic                          o_full,
  output logic                          o_err
);

  localparam int unsigned NREG = 2**REG_AW;
  localparam int unsigned CW   = CNT_W(MAX_OUT);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_err;
  logic            w_err_nxt;

  // Clear before set so a same-index issue and response leaves the bit pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_resp) begin
      w_pend_nxt[i_resp_rd] = 1'b0;
    end
    if (i_issue && (i_issue_rd != REG_AW'(REG_ZERO))) begin
      w_pend_nxt[i_issue_rd] = 1'b1;
    end
  end

  // Saturating counter; overflow and underflow attempts latch the error.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    if (i_issue && !i_resp) begin
      if (r_cnt == CW'(MAX_OUT)) begin
        w_err_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else if (i_resp && !i_issue) begin
      if (r_cnt == CW'(0)) begin
        w_err_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign o_pend    = r_pend;
  assign o_out_cnt = r_cnt;
  assign o_full    = (r_cnt == CW'(MAX_OUT));
  assign o_err     = r_err;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard detector for variable-latency loads: load-use, pending-register
// and structural (in-flight limit) hazards. Optional macro: HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int unsigned NREG = 2**REG_AW;
  localparam int unsigned CW   = CNT_W(MAX_OUT);
  localparam int unsigned SW   = CW + 1;

  logic [NREG-1:0] w_pend;
  logic [CW-1:0]   w_out_cnt;
  logic            w_full;
  logic            w_err;
  logic            w_load_use;
  logic            w_pend_hit;
  logic            w_struct;
  logic            w_stall;

  hazard_sb_core #(
    .REG_AW  (REG_AW),
    .MAX_OUT (MAX_OUT)
  ) u_core (
    .clk        (clk_i),
    .i_rst_n    (rst_i),
    .i_issue    (bus.Issue_i),
    .i_issue_rd (bus.Issue_RD_i),
    .i_resp     (bus.MemResp_i),
    .i_resp_rd  (bus.MemResp_RD_i),
    .o_pend     (w_pend),
    .o_out_cnt  (w_out_cnt),
    .o_full     (w_full),
    .o_err      (w_err)
  );

  // Per-operand compare; a same-cycle writeback of a pending source is forwarded.
  always_comb begin
    w_load_use = 1'b0;
    w_pend_hit = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      logic [REG_AW-1:0] v_src;
      v_src = bus.IFID_RS_i[k*REG_AW +: REG_AW];
      if (bus.IFID_RSUse_i[k]) begin
        if (bus.IDEX_MemRead_i && (bus.IDEX_RD_i != REG_AW'(REG_ZERO)) &&
            (bus.IDEX_RD_i == v_src)) begin
          w_load_use = 1'b1;
        end
        if (w_pend[v_src] && !(bus.MemResp_i && (bus.MemResp_RD_i == v_src))) begin
          w_pend_hit = 1'b1;
        end
      end
    end
  end

  // A new load may not enter while the in-flight count (net of this cycle's response) is at the limit.
  assign w_struct = bus.IFID_MemRead_i &&
                    ((SW'(w_out_cnt) + SW'(bus.IDEX_MemRead_i)) >=
                     (SW'(MAX_OUT) + SW'(bus.MemResp_i)));

  assign w_stall = (w_load_use || w_pend_hit || w_struct) && !bus.Flush_i;

  assign bus.PCWrite_o = !w_stall;
  assign bus.Stall_o   = w_stall;
  assign bus.NoOp_o    = w_stall;
  assign bus.Full_o    = w_full;
  assign bus.Err_o     = w_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.StallCnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: expectations queued at drive time,
// popped and checked mid-cycle before the committing clock edge.
module tb_hazard_scoreboard_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned MAX_OUT = 2;

  typedef struct {
    string tag;
    bit    stall;
    bit    full;
    bit    err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t q_exp[$];

  hazard_scoreboard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) bus ();

  hazard_scoreboard_unit #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .MAX_OUT (MAX_OUT)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.IFID_RS_i      = '0;
    bus.IFID_RSUse_i   = '0;
    bus.IFID_MemRead_i = 1'b0;
    bus.IDEX_MemRead_i = 1'b0;
    bus.IDEX_RD_i      = '0;
    bus.Issue_i        = 1'b0;
    bus.Issue_RD_i     = '0;
    bus.MemResp_i      = 1'b0;
    bus.MemResp_RD_i   = '0;
    bus.Flush_i        = 1'b0;
  endtask

  task automatic cmp1(input string tag, input string fld, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  // Push expectation for the inputs just driven, settle, pop and compare, then clock.
  task automatic step(input string tag, input bit st, input bit full, input bit err);
    exp_t e;
    e.tag = tag; e.stall = st; e.full = full; e.err = err;
    q_exp.push_back(e);
    #2;
    e = q_exp.pop_front();
    cmp1(e.tag, "Stall_o",   bus.Stall_o,   e.stall);
    cmp1(e.tag, "NoOp_o",    bus.NoOp_o,    e.stall);
    cmp1(e.tag, "PCWrite_o", bus.PCWrite_o, !e.stall);
    cmp1(e.tag, "Full_o",    bus.Full_o,    e.full);
    cmp1(e.tag, "Err_o",     bus.Err_o,     e.err);
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step("reset", 0, 0, 0);
    rst_n = 1'b1;

    // Load-use against the EX load
    bus.IDEX_MemRead_i = 1; bus.IDEX_RD_i = 5'd5;
    bus.IFID_RS_i = {5'd5, 5'd3}; bus.IFID_RSUse_i = 2'b11;
    step("loaduse", 1, 0, 0);
    bus.IDEX_MemRead_i = 1; bus.IDEX_RD_i = 5'd0;
    bus.IFID_RS_i = {5'd0, 5'd3}; bus.IFID_RSUse_i = 2'b11;
    step("loaduse_x0", 0, 0, 0);
    bus.IDEX_MemRead_i = 1; bus.IDEX_RD_i = 5'd5;
    bus.IFID_RS_i = {5'd5, 5'd3}; bus.IFID_RSUse_i = 2'b01;
    step("loaduse_unused", 0, 0, 0);

    // Variable latency on x7
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd7;
    step("issue7", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus.IFID_RS_i = {5'd0, 5'd7}; bus.IFID_RSUse_i = 2'b01;
      step("wait7", 1, 0, 0);
    end
    bus.IFID_RS_i = {5'd0, 5'd7}; bus.IFID_RSUse_i = 2'b01;
    bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd7;
    step("resp7_fwd", 0, 0, 0);
    bus.IFID_RS_i = {5'd7, 5'd0}; bus.IFID_RSUse_i = 2'b10;
    step("after7", 0, 0, 0);

    // Structural limit
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd10;
    step("issue10", 0, 0, 0);
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd11;
    step("issue11", 0, 0, 0);
    bus.IFID_MemRead_i = 1;
    step("full_load", 1, 1, 0);
    bus.IFID_RS_i = {5'd0, 5'd3}; bus.IFID_RSUse_i = 2'b01;
    step("full_nonload", 0, 1, 0);
    bus.IFID_MemRead_i = 1; bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd10;
    step("full_load_resp", 0, 1, 0);
    step("unfull", 0, 0, 0);
    bus.IFID_MemRead_i = 1; bus.IDEX_MemRead_i = 1; bus.IDEX_RD_i = 5'd20;
    step("struct_idex", 1, 0, 0);

    // Simultaneous issue and response on x9
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd9;
    bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd9;
    step("setclr9", 0, 0, 0);
    bus.IFID_RS_i = {5'd0, 5'd9}; bus.IFID_RSUse_i = 2'b01;
    step("pend9", 1, 0, 0);
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd12;
    step("issue12", 0, 0, 0);
    step("cnt_kept", 0, 1, 0);

    // Flush overrides the hazard and leaves the scoreboard intact
    bus.IFID_RS_i = {5'd0, 5'd9}; bus.IFID_RSUse_i = 2'b01; bus.Flush_i = 1;
    step("flush", 0, 1, 0);
    bus.IFID_RS_i = {5'd0, 5'd9}; bus.IFID_RSUse_i = 2'b01;
    step("post_flush", 1, 1, 0);
    bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd9;
    step("resp9", 0, 1, 0);
    bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd11;
    step("resp11", 0, 0, 0);
    bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd12;
    step("resp_empty", 0, 0, 0);
    step("err_set", 0, 0, 1);
    step("err_sticky", 0, 0, 1);
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd0;
    step("issue_x0", 0, 0, 1);
    bus.IFID_RS_i = {5'd0, 5'd0}; bus.IFID_RSUse_i = 2'b11;
    step("x0_nopend", 0, 0, 1);

    // Reset mid-operation (x4 pending, counter full)
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd4;
    step("issue4", 0, 0, 1);
    rst_n = 1'b0;
    step("mid_reset", 0, 1, 1);
    rst_n = 1'b1;
    bus.IFID_MemRead_i = 1; bus.IFID_RS_i = {5'd0, 5'd4}; bus.IFID_RSUse_i = 2'b01;
    step("post_reset", 0, 0, 0);
    bus.MemResp_i = 1; bus.MemResp_RD_i = 5'd4;
    step("stale_resp", 0, 0, 0);
    step("stale_err", 0, 0, 1);

    // Overflow attempt saturates and flags
    rst_n = 1'b0;
    step("reset2", 0, 0, 1);
    rst_n = 1'b1;
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd1;
    step("ov_i1", 0, 0, 0);
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd2;
    step("ov_i2", 0, 0, 0);
    bus.Issue_i = 1; bus.Issue_RD_i = 5'd3;
    step("ov_i3", 0, 1, 0);
    step("ov_err", 0, 1, 1);

`ifdef HAZARD_PERF_CNT_EN
    rst_n = 1'b0;
    step("reset3", 0, 1, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IDEX_MemRead_i = 1; bus.IDEX_RD_i = 5'd6;
      bus.IFID_RS_i = {5'd6, 5'd0}; bus.IFID_RSUse_i = 2'b10;
      step("perf_stall", 1, 0, 0);
    end
    #2;
    n_cmp++;
    assert (bus.StallCnt_o === 32'd3) else begin
      n_bad++;
      $error("FAIL stallcnt observed=%0d expected=3", bus.StallCnt_o);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
